// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Package : mux_pkg
// Purpose : Types and constants shared by the 2:1 mux stage and its
//           upstream round-robin arbiter (mux_sel_arbiter).
//           - state_e : arbitration FSM states
//           - SEL_A / SEL_B : select-line encoding seen by the mux
// Revision: 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_sel_arbiter_out_slot.sv
`default_nettype none
// ============================================================================
// Module  : out_slot_reg
// Purpose : One-entry valid/ready output register holding data, last flag
//           and mux select for a single beat.
// Ports   : clk, rst_n         - clock, async active-low reset
//           i_load             - capture i_data/i_last/i_sel this edge
//           i_data/i_last/i_sel- beat to capture
//           i_out_ready        - downstream accepts the held beat
//           o_valid/o_data/o_last/o_sel - registered beat
//           o_slot_free        - slot can take a new beat this cycle
// Revision: 1.0 - initial release
// ============================================================================
module out_slot_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_sel,
    input  logic             i_out_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_sel,
    output logic             o_slot_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             r_sel;

    // The upstream only loads when the slot is free, so a load always
    // overwrites either an empty slot or a beat leaving this very edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_sel   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_sel   <= i_sel;
        end else if (i_out_ready) begin
            // Beat drained, nothing new: payload is left as-is, only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_last      = r_last;
    assign o_sel       = r_sel;
    assign o_slot_free = ~r_valid | i_out_ready;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_sel_arbiter
// Purpose : Two-source round-robin packet arbiter driving the sel line of
//           the downstream 2:1 mux. Holds a grant for a whole packet or up
//           to MAX_BURST beats, forwarding beats through one registered slot.
// Ports   : clk, rst_n                      - clock, async active-low reset
//           i_a_valid/i_a_data/i_a_last     - source A beat
//           o_a_ready                       - source A beat accepted
//           i_b_valid/i_b_data/i_b_last     - source B beat
//           o_b_ready                       - source B beat accepted
//           o_out_valid/o_out_data/o_out_last, i_out_ready - output beat
//           o_sel                           - 0 = beat from A, 1 = from B
//           o_busy                          - a grant is active
// Revision: 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a_valid,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic             i_a_last,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [WIDTH-1:0] i_b_data,
    input  logic             i_b_last,
    output logic             o_b_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    input  logic             i_out_ready,
    output logic             o_sel,
    output logic             o_busy
);

    state_e           r_state;
    logic             r_prio;
    logic [CNT_W-1:0] r_burst_cnt;

    logic             w_slot_free;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_a_acc;
    logic             w_b_acc;
    logic             w_acc;
    logic [WIDTH-1:0] w_acc_data;
    logic             w_acc_last;
    logic             w_acc_sel;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_burst_full;
    logic             w_release;

    // Ready is only offered by the granted source, and only when the output
    // slot can absorb the beat this cycle.
    assign w_a_ready  = (r_state == GRANT_A) & w_slot_free;
    assign w_b_ready  = (r_state == GRANT_B) & w_slot_free;
    assign w_a_acc    = w_a_ready & i_a_valid;
    assign w_b_acc    = w_b_ready & i_b_valid;
    assign w_acc      = w_a_acc | w_b_acc;

    assign w_acc_data = w_b_acc ? i_b_data : i_a_data;
    assign w_acc_last = w_b_acc ? i_b_last : i_a_last;
    assign w_acc_sel  = w_b_acc ? SEL_B : SEL_A;

    // A beat that ends the packet or fills the burst budget closes the grant;
    // both at once still produce exactly one release.
    assign w_cnt_next   = r_burst_cnt + CNT_W'(1);
    assign w_burst_full = (w_cnt_next == CNT_W'(MAX_BURST));
    assign w_release    = w_acc & (w_acc_last | w_burst_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prio      <= SEL_A;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Decision uses valids only; no beat is taken this cycle.
                    if (i_a_valid && (!i_b_valid || r_prio == SEL_A)) begin
                        r_state <= GRANT_A;
                    end else if (i_b_valid) begin
                        r_state <= GRANT_B;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (w_release) begin
                        r_state     <= IDLE;
                        r_burst_cnt <= '0;
                        r_prio      <= (r_state == GRANT_A) ? SEL_B : SEL_A;
                    end else if (w_acc) begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    out_slot_reg #(
        .WIDTH (WIDTH)
    ) u_out_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_acc),
        .i_data      (w_acc_data),
        .i_last      (w_acc_last),
        .i_sel       (w_acc_sel),
        .i_out_ready (i_out_ready),
        .o_valid     (o_out_valid),
        .o_data      (o_out_data),
        .o_last      (o_out_last),
        .o_sel       (o_sel),
        .o_slot_free (w_slot_free)
    );

    assign o_a_ready = w_a_ready;
    assign o_b_ready = w_b_ready;
    assign o_busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_sel_arbiter
// Purpose : Self-checking bench for mux_sel_arbiter (MAX_BURST = 4).
//           Sources are modelled as beat queues; output beats are captured
//           and compared with an order predicted at packet/chunk level.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, a_last, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             out_valid, out_last, out_ready, sel, busy;
    logic [WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Source beat queues (front is the beat currently presented)
    logic [7:0] qa_d[$];
    logic       qa_l[$];
    logic [7:0] qb_d[$];
    logic       qb_l[$];
    bit         a_block, b_block;

    // Captured output transfers: {sel, last, data} and cycle index
    logic [9:0] cap[$];
    int         cap_cyc[$];

    // Values sampled at the negedge of the most recent tick
    logic       s_ov, s_or, s_ol, s_sel, s_busy, s_ar, s_br;
    logic [7:0] s_od;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_a_valid   (a_valid),
        .i_a_data    (a_data),
        .i_a_last    (a_last),
        .o_a_ready   (a_ready),
        .i_b_valid   (b_valid),
        .i_b_data    (b_data),
        .i_b_last    (b_last),
        .o_b_ready   (b_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .i_out_ready (out_ready),
        .o_sel       (sel),
        .o_busy      (busy)
    );

    function automatic logic [9:0] bt(input logic s, input logic l, input logic [7:0] d);
        return {s, l, d};
    endfunction

    // One clock cycle: present queue fronts, sample at negedge, pop on handshake.
    task automatic tick();
        logic a_hs, b_hs;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        if (qa_d.size() > 0 && !a_block) begin
            a_valid = 1'b1; a_data = qa_d[0]; a_last = qa_l[0];
        end
        if (qb_d.size() > 0 && !b_block) begin
            b_valid = 1'b1; b_data = qb_d[0]; b_last = qb_l[0];
        end
        @(negedge clk);
        s_ov = out_valid; s_or = out_ready; s_ol = out_last; s_od = out_data;
        s_sel = sel; s_busy = busy; s_ar = a_ready; s_br = b_ready;
        a_hs = a_valid & a_ready;
        b_hs = b_valid & b_ready;
        if (out_valid && out_ready) begin
            cap.push_back(bt(sel, out_last, out_data));
            cap_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (a_hs) begin void'(qa_d.pop_front()); void'(qa_l.pop_front()); end
        if (b_hs) begin void'(qb_d.pop_front()); void'(qb_l.pop_front()); end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa_d.delete(); qa_l.delete(); qb_d.delete(); qb_l.delete();
        cap.delete(); cap_cyc.delete();
        a_block = 0; b_block = 0; out_ready = 1'b0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] exp[$];
        do_reset();
        tick();
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", s_ov); end
        n_checks++; if (s_od !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", s_od); end
        n_checks++; if ({s_sel, s_ol, s_busy, s_ar, s_br} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got sel/last/busy/ar/br=%b want 00000", {s_sel, s_ol, s_busy, s_ar, s_br});
        end
        // Park a B beat in the output register, then reset mid-stream.
        qb_d = '{8'h77, 8'h78}; qb_l = '{1'b0, 1'b1};
        out_ready = 1'b0;
        repeat (3) tick();
        n_checks++; if (s_ov !== 1'b1 || s_sel !== 1'b1) begin
            n_fail++; $display("FAIL reset_preload: got valid=%b sel=%b want 1 1", s_ov, s_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, sel, busy, a_ready, b_ready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_async: got valid/sel/busy/ar/br=%b want 00000", {out_valid, sel, busy, a_ready, b_ready});
        end
        do_reset();
        // Prio must be back on A: a tie resolves to A first.
        qa_d = '{8'h31}; qa_l = '{1'b1};
        qb_d = '{8'h41}; qb_l = '{1'b1};
        out_ready = 1'b1;
        repeat (8) tick();
        exp = '{bt(1'b0, 1'b1, 8'h31), bt(1'b1, 1'b1, 8'h41)};
        n_checks++; if (cap.size() !== exp.size()) begin n_fail++; $display("FAIL reset_prio_count: got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL reset_prio_beat%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 10'h3ff, exp[i]);
            end
        end
    endtask

    task automatic test_single();
        int t0;
        logic [9:0] exp[$];
        do_reset();
        qa_d = '{8'h11, 8'h22, 8'h33}; qa_l = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        t0 = cyc;
        repeat (6) tick();
        exp = '{bt(1'b0, 1'b0, 8'h11), bt(1'b0, 1'b0, 8'h22), bt(1'b0, 1'b1, 8'h33)};
        n_checks++; if (cap.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", cap.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= cap.size() || cap[i] !== exp[i] || cap_cyc[i] !== t0 + 2 + i) begin
                n_fail++; $display("FAIL single_beat%0d: got %h at cycle %0d want %h at cycle %0d", i,
                    (i < cap.size()) ? cap[i] : 10'h3ff, (i < cap.size()) ? cap_cyc[i] - t0 : -1, exp[i], 2 + i);
            end
        end
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", s_busy); end
    endtask

    task automatic test_contention();
        logic [9:0] exp[$];
        do_reset();
        qa_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4}; qa_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        qb_d = '{8'hB1, 8'hB2};               qb_l = '{1'b0, 1'b1};
        out_ready = 1'b1;
        repeat (16) tick();
        exp = '{bt(0, 0, 8'hA1), bt(0, 1, 8'hA2), bt(1, 0, 8'hB1), bt(1, 1, 8'hB2),
                bt(0, 0, 8'hA3), bt(0, 1, 8'hA4)};
        n_checks++; if (cap.size() !== exp.size()) begin n_fail++; $display("FAIL contention_count: got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL contention_beat%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 10'h3ff, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0;
        do_reset();
        qa_d = '{8'h5A, 8'h6B, 8'h7C}; qa_l = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b0;
        t0 = cyc;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (s_ov !== 1'b1 || s_od !== 8'h5A || s_sel !== 1'b0 || s_ar !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%h sel=%b a_ready=%b want 1 5a 0 0", i, s_ov, s_od, s_sel, s_ar);
            end
        end
        out_ready = 1'b1;
        repeat (5) tick();
        n_checks++; if (cap.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", cap.size()); end
        n_checks++;
        if (cap.size() < 3 || cap[0] !== bt(0, 0, 8'h5A) || cap[1] !== bt(0, 0, 8'h6B) || cap[2] !== bt(0, 1, 8'h7C)
            || cap_cyc[0] !== t0 + 6 || cap_cyc[1] !== t0 + 7 || cap_cyc[2] !== t0 + 8) begin
            n_fail++; $display("FAIL bp_resume: got %0d beats first=%h at %0d want 5a/6b/7c at cycles 6/7/8",
                cap.size(), (cap.size() > 0) ? cap[0] : 10'h3ff, (cap.size() > 0) ? cap_cyc[0] - t0 : -1);
        end
    endtask

    task automatic test_burst_limit();
        logic [9:0] exp[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin qb_d.push_back(8'hC0 + 8'(i)); qb_l.push_back(1'b0); end
        qa_d = '{8'hD0, 8'hD1}; qa_l = '{1'b0, 1'b1};
        out_ready = 1'b1;
        a_block = 1;
        tick();
        a_block = 0;
        repeat (20) tick();
        exp = '{bt(1, 0, 8'hC0), bt(1, 0, 8'hC1), bt(1, 0, 8'hC2), bt(1, 0, 8'hC3),
                bt(0, 0, 8'hD0), bt(0, 1, 8'hD1), bt(1, 0, 8'hC4), bt(1, 0, 8'hC5)};
        n_checks++; if (cap.size() !== exp.size()) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL burst_beat%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 10'h3ff, exp[i]);
            end
        end
        // B's split packet never saw last, so its grant is still held.
        n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy_hold: got %b want 1", s_busy); end
    endtask

    task automatic test_gap();
        logic [9:0] exp[$];
        int gap;
        do_reset();
        qa_d = '{8'hE0, 8'hE1, 8'hE2}; qa_l = '{1'b0, 1'b0, 1'b1};
        qb_d = '{8'hF0};               qb_l = '{1'b1};
        out_ready = 1'b1;
        gap = 0;
        for (int t = 0; t < 16; t++) begin
            a_block = (qa_d.size() == 2 && gap < 3);
            tick();
            if (a_block) begin
                gap++;
                n_checks++;
                if (s_br !== 1'b0 || s_busy !== 1'b1) begin
                    n_fail++; $display("FAIL gap_hold%0d: got b_ready=%b busy=%b want 0 1", gap, s_br, s_busy);
                end
            end
        end
        a_block = 0;
        n_checks++; if (gap !== 3) begin n_fail++; $display("FAIL gap_cycles: got %0d want 3", gap); end
        exp = '{bt(0, 0, 8'hE0), bt(0, 0, 8'hE1), bt(0, 1, 8'hE2), bt(1, 1, 8'hF0)};
        n_checks++; if (cap.size() !== exp.size()) begin n_fail++; $display("FAIL gap_count: got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL gap_beat%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 10'h3ff, exp[i]);
            end
        end
    endtask

    // Random packets, random backpressure. Expected order comes from a
    // chunk-level round-robin model over the two beat streams.
    task automatic test_random();
        logic [7:0] ma_d[$], mb_d[$];
        logic       ma_l[$], mb_l[$];
        logic [9:0] exp[$];
        logic       prio, s, l, p_hold, p_sel, p_last;
        logic [7:0] d, p_data;
        int         n, len, budget;
        bit         done;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            exp.delete();
            for (int src = 0; src < 2; src++) begin
                for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                    len = $urandom_range(1, 6);
                    for (int j = 0; j < len; j++) begin
                        d = 8'($urandom);
                        if (src == 0) begin qa_d.push_back(d); qa_l.push_back(j == len - 1); end
                        else          begin qb_d.push_back(d); qb_l.push_back(j == len - 1); end
                    end
                end
            end
            ma_d = qa_d; ma_l = qa_l; mb_d = qb_d; mb_l = qb_l;
            prio = 1'b0;
            while (ma_d.size() > 0 || mb_d.size() > 0) begin
                s = (ma_d.size() > 0 && (mb_d.size() == 0 || prio == 1'b0)) ? 1'b0 : 1'b1;
                n = 0; done = 0;
                while (!done) begin
                    if (s == 1'b0) begin d = ma_d.pop_front(); l = ma_l.pop_front(); end
                    else           begin d = mb_d.pop_front(); l = mb_l.pop_front(); end
                    exp.push_back(bt(s, l, d));
                    n++;
                    if (l || n == MAX_BURST || (s == 1'b0 ? ma_d.size() : mb_d.size()) == 0) done = 1;
                end
                prio = ~s;
            end
            budget = 0;
            p_hold = 1'b0; p_data = '0; p_sel = 1'b0; p_last = 1'b0;
            while (cap.size() < exp.size() && budget < 600) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                budget++;
                if (p_hold) begin
                    n_checks++;
                    if (s_ov !== 1'b1 || s_od !== p_data || s_sel !== p_sel || s_ol !== p_last) begin
                        n_fail++; $display("FAIL rand%0d_stable: got v=%b d=%h s=%b l=%b want 1 %h %b %b",
                            r, s_ov, s_od, s_sel, s_ol, p_data, p_sel, p_last);
                    end
                end
                p_hold = s_ov & ~s_or;
                p_data = s_od; p_sel = s_sel; p_last = s_ol;
            end
            n_checks++;
            if (budget >= 600) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d beats want %0d", r, cap.size(), exp.size()); end
            for (int i = 0; i < exp.size(); i++) begin
                n_checks++;
                if (i >= cap.size() || cap[i] !== exp[i]) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got %h want %h", r, i, (i < cap.size()) ? cap[i] : 10'h3ff, exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_burst_limit();
        test_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
